// File: rtl/vpu_pkg.sv
// Shared types and default tile geometry for the vector result path.
// Tile geometry defaults and the drain-unit state encoding.
package vpu_pkg;

  localparam int ROW_A_DEF     = 4;
  localparam int COL_W_DEF     = 4;
  localparam int ACC_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_e;

  typedef logic signed [ACC_WIDTH_DEF-1:0] elem_t;

endpackage

// File: rtl/vpu_store_if.sv
// Valid/ready data stream used for the capture and row-output buses.
// Parameterised on payload width.
interface vpu_store_if #(
  parameter int W = 128
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/vpu_store_row_sel.sv
// Combinational row picker/packer for the store tile, with column bypass.
// Optional ReLU clamp when VPU_STORE_RELU_EN is defined.
module vpu_store_row_sel
  import vpu_pkg::*;
#(
  parameter int ROW_A     = ROW_A_DEF,
  parameter int COL_W     = COL_W_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int RW        = (ROW_A > 1) ? $clog2(ROW_A) : 1
) (
  input  logic [ACC_WIDTH-1:0]       mem_i [ROW_A][COL_W],
  input  logic [RW-1:0]              row_i,
  input  logic [ROW_A*ACC_WIDTH-1:0] byp_col_i,
  input  logic                       byp_en_i,
  output logic [COL_W*ACC_WIDTH-1:0] row_o
);

  logic [ACC_WIDTH-1:0] byp_elem;
  logic [ACC_WIDTH-1:0] elem;

  always_comb begin
    row_o    = '0;
    elem     = '0;
    byp_elem = byp_col_i[row_i*ACC_WIDTH +: ACC_WIDTH];
    for (int c = 0; c < COL_W; c++) begin
      elem = mem_i[row_i][c];
      // Last column may still be in flight on the capture bus.
      if (byp_en_i && (c == COL_W - 1))
        elem = byp_elem;
`ifdef VPU_STORE_RELU_EN
      if (elem[ACC_WIDTH-1])
        elem = '0;
`else
`endif
      row_o[c*ACC_WIDTH +: ACC_WIDTH] = elem;
    end
  end

endmodule

// File: rtl/vpu_store.sv
// Result-drain unit: captures a tile by columns, streams it out by rows.
// Build option VPU_STORE_RELU_EN clamps negative elements on output.
module vpu_store
  import vpu_pkg::*;
#(
  parameter int ROW_A     = ROW_A_DEF,
  parameter int COL_W     = COL_W_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  vpu_store_if.slave   cap_i,
  vpu_store_if.master  out_o,
  output logic         out_last_o,
  output logic         tile_done_o,
  output logic         busy_o
);

  localparam int RW = (ROW_A > 1) ? $clog2(ROW_A) : 1;
  localparam int CW = (COL_W > 1) ? $clog2(COL_W) : 1;
  localparam int OW = COL_W * ACC_WIDTH;

  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_A - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL_W - 1);

  state_e state_q, state_d;

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          tile_done_q, tile_done_d;

  logic [ACC_WIDTH-1:0] c_mem_q [ROW_A][COL_W];

  logic          cap_fire;
  logic          out_fire;
  logic [RW-1:0] next_row;
  logic [RW-1:0] sel_row;
  logic          byp_en;
  logic [OW-1:0] sel_data;

  assign cap_i.ready = (state_q != DRAIN);
  assign cap_fire    = cap_i.valid && cap_i.ready;
  assign out_fire    = out_valid_q && out_o.ready;

  assign next_row = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
  assign sel_row  = (state_q == DRAIN) ? next_row : '0;
  assign byp_en   = (state_q != DRAIN);

  vpu_store_row_sel #(
    .ROW_A     (ROW_A),
    .COL_W     (COL_W),
    .ACC_WIDTH (ACC_WIDTH),
    .RW        (RW)
  ) u_row_sel (
    .mem_i     (c_mem_q),
    .row_i     (sel_row),
    .byp_col_i (cap_i.data),
    .byp_en_i  (byp_en),
    .row_o     (sel_data)
  );

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    tile_done_d = 1'b0;
    unique case (state_q)
      IDLE, CAPTURE: begin
        if (cap_fire) begin
          if (col_cnt_q == COL_LAST) begin
            state_d     = DRAIN;
            col_cnt_d   = '0;
            row_cnt_d   = '0;
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = (ROW_A == 1);
          end else begin
            state_d   = CAPTURE;
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (out_last_q) begin
            state_d     = IDLE;
            row_cnt_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            tile_done_d = 1'b1;
          end else begin
            row_cnt_d  = next_row;
            out_data_d = sel_data;
            out_last_d = (next_row == ROW_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Tile storage is left uninitialised; every entry is rewritten per tile.
  always_ff @(posedge clk) begin
    if (cap_fire) begin
      for (int r = 0; r < ROW_A; r++)
        c_mem_q[r][col_cnt_q] <= cap_i.data[r*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  assign out_o.valid = out_valid_q;
  assign out_o.data  = out_data_q;
  assign out_last_o  = out_last_q;
  assign tile_done_o = tile_done_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_vpu_store.sv
// Directed self-checking bench for vpu_store (4x4 tile, 32-bit elements).
// Honours VPU_STORE_RELU_EN when computing expected rows.
module tb_vpu_store;

  logic clk;
  logic reset;
  logic out_last;
  logic tile_done;
  logic busy;

  int n_tot;
  int n_pass;

  logic [31:0] tile [4][4];

  vpu_store_if #(.W(128)) cap_if ();
  vpu_store_if #(.W(128)) out_if ();

  vpu_store dut (
    .clk         (clk),
    .reset       (reset),
    .cap_i       (cap_if),
    .out_o       (out_if),
    .out_last_o  (out_last),
    .tile_done_o (tile_done),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tile[r][c] = base + 32'(r * 16 + c);
  endtask

  function automatic logic [127:0] col_of(input int c);
    logic [127:0] v;
    for (int r = 0; r < 4; r++) v[r*32 +: 32] = tile[r][c];
    return v;
  endfunction

  function automatic logic [127:0] row_of(input int r);
    logic [127:0] v;
    logic [31:0]  e;
    for (int c = 0; c < 4; c++) begin
      e = tile[r][c];
`ifdef VPU_STORE_RELU_EN
      if (e[31]) e = 32'h0;
`endif
      v[c*32 +: 32] = e;
    end
    return v;
  endfunction

  task automatic capture(input int ncol, input int gap);
    for (int c = 0; c < ncol; c++) begin
      cap_if.valid = 1'b1;
      cap_if.data  = col_of(c);
      chk("cap_rdy", 128'(cap_if.ready), 128'(1));
      step();
      cap_if.valid = 1'b0;
      cap_if.data  = '0;
      if (c < ncol - 1)
        for (int g = 0; g < gap; g++) begin
          chk("gap_novld", 128'(out_if.valid), 128'(0));
          step();
        end
    end
  endtask

  // patsel 0: ready always 1; patsel 1: ready 1,0,0,1 repeating
  task automatic drain(input int patsel, input bit junk);
    logic [127:0] held;
    logic         hl;
    bit           hv;
    int           n;
    int           cyc;
    hv = 0; n = 0; cyc = 0; held = '0; hl = 1'b0;
    chk("first_vld", 128'(out_if.valid), 128'(1));
    chk("td_early", 128'(tile_done), 128'(0));
    while (n < 4 && cyc < 64) begin
      out_if.ready = (patsel == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (junk) begin
        cap_if.valid = 1'b1;
        cap_if.data  = {4{32'h0000DEAD}};
        chk("cap_rdy_drn", 128'(cap_if.ready), 128'(0));
      end
      chk("vld_drn", 128'(out_if.valid), 128'(1));
      if (hv) begin
        chk("hold_data", out_if.data, held);
        chk("hold_last", 128'(out_last), 128'(hl));
      end
      if (out_if.valid && out_if.ready) begin
        chk("row_data", out_if.data, row_of(n));
        chk("row_last", 128'(out_last), 128'(n == 3));
        n++;
        hv = 0;
      end else begin
        held = out_if.data;
        hl   = out_last;
        hv   = 1;
      end
      step();
      cyc++;
    end
    cap_if.valid = 1'b0;
    cap_if.data  = '0;
    out_if.ready = 1'b0;
    chk("drn_rows", 128'(n), 128'(4));
    if (patsel == 0) chk("drn_cyc", 128'(cyc), 128'(4));
    else chk("drn_cyc_stall", 128'(cyc), 128'(8));
    chk("td_pulse", 128'(tile_done), 128'(1));
    chk("vld_end", 128'(out_if.valid), 128'(0));
    chk("last_end", 128'(out_last), 128'(0));
    chk("cap_rdy_end", 128'(cap_if.ready), 128'(1));
    chk("busy_end", 128'(busy), 128'(0));
    step();
    chk("td_clear", 128'(tile_done), 128'(0));
  endtask

  initial begin
    n_tot = 0;
    n_pass = 0;
    reset = 1'b1;
    cap_if.valid = 1'b0;
    cap_if.data  = '0;
    out_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 128'(out_if.valid), 128'(0));
    chk("rst_data", out_if.data, 128'(0));
    chk("rst_last", 128'(out_last), 128'(0));
    chk("rst_td", 128'(tile_done), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_caprdy", 128'(cap_if.ready), 128'(1));
    reset = 1'b0;
    step();

    fill(32'h0);
    capture(4, 0);
    drain(0, 0);

    fill(32'h100);
    capture(4, 0);
    drain(1, 0);

    fill(32'h200);
    capture(4, 0);
    drain(0, 1);

    fill(32'h300);
    capture(4, 1);
    drain(0, 0);

    fill(32'h400);
    capture(2, 0);
    chk("mid_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_vld", 128'(out_if.valid), 128'(0));
    chk("abort_td", 128'(tile_done), 128'(0));
    fill(32'h500);
    capture(4, 0);
    drain(0, 0);

    fill(32'h600);
    tile[2][3] = 32'hFFFFFFF0;
    tile[1][0] = 32'hFFFFFFF0;
    capture(4, 0);
    drain(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
